// File: rtl/parity_pkg.sv
// Shared types for the parity frame accumulator.
//   state_t    : frame sequencing states (IDLE, ACCUM, DONE)
//   par_mode_t : parity sense latched per frame (even / odd)
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_mode_t;

endpackage

// File: rtl/parity_frame_acc_if.sv
// Stream interface for parity_frame_acc.
//   Input side : clear, mode, in_valid/in_ready, in_data
//   Output side: out_valid/out_ready, out_row_par, out_col_par, out_par, out_cnt
//   master : word source / result consumer
//   slave  : the accumulator
interface parity_frame_acc_if #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4
);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  logic                 clear;
  logic                 mode;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [FRAME_LEN-1:0] out_row_par;
  logic [WIDTH-1:0]     out_col_par;
  logic                 out_par;
  logic [CNT_W-1:0]     out_cnt;

  modport master (
    output clear, mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_row_par, out_col_par, out_par, out_cnt
  );

  modport slave (
    input  clear, mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_row_par, out_col_par, out_par, out_cnt
  );
endinterface

// File: rtl/parity_tree.sv
// Combinational reduction-XOR parity of a WIDTH-bit vector, optionally
// inverted (the generalised XOR3 cell).
//   data   : bits to reduce
//   invert : 1 flips the result (odd parity)
//   par    : ^data ^ invert
module parity_tree #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] data,
  input  logic             invert,
  output logic             par
);
  // Linear chain seeded with the invert bit; synthesis rebalances it.
  logic [WIDTH:0] chain;

  assign chain[0] = invert;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_xor
    assign chain[gi+1] = chain[gi] ^ data[gi];
  end

  assign par = chain[WIDTH];
endmodule

// File: rtl/parity_frame_acc.sv
// Groups WIDTH-bit words into frames of FRAME_LEN and produces per-word
// (row) parity, bitwise column parity and overall frame parity, even or odd.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : parity_frame_acc_if slave (input stream, held result output)
module parity_frame_acc
  import parity_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  parity_frame_acc_if.slave bus
);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg;
  logic [FRAME_LEN-1:0] row_reg, row_next;
  logic [WIDTH-1:0]     col_reg;
  par_mode_t            mode_q_reg;

  logic mode_q_bit, mode_eff, word_par;
  logic accept, release_frame, last_word;

  assign mode_q_bit    = (mode_q_reg == PAR_ODD);
  // The first word of a frame uses the live mode input; later words use the latch.
  assign mode_eff      = (state_reg == IDLE) ? bus.mode : mode_q_bit;
  // clear wins over both handshakes.
  assign accept        = bus.in_valid && bus.in_ready && !bus.clear;
  assign release_frame = bus.out_valid && bus.out_ready && !bus.clear;
  assign last_word     = (cnt_reg == CNT_W'(FRAME_LEN - 1));

  parity_tree #(.WIDTH(WIDTH)) u_word_par (
    .data   (bus.in_data),
    .invert (mode_eff),
    .par    (word_par)
  );

  // Column accumulator is kept un-inverted; odd mode is applied here once.
  parity_tree #(.WIDTH(WIDTH)) u_frame_par (
    .data   (col_reg),
    .invert (mode_q_bit),
    .par    (bus.out_par)
  );

  // Only the row slot addressed by the word counter takes the new parity bit.
  for (genvar gi = 0; gi < FRAME_LEN; gi++) begin : g_row
    assign row_next[gi] = (cnt_reg == CNT_W'(gi)) ? word_par : row_reg[gi];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (bus.clear) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (accept) state_next = (FRAME_LEN == 1) ? DONE : ACCUM;
        ACCUM:   if (accept && last_word) state_next = DONE;
        DONE:    if (release_frame) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    bus.in_ready  = (state_reg != DONE);
    bus.out_valid = (state_reg == DONE);
  end

  // Accumulators
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      row_reg    <= '0;
      col_reg    <= '0;
      mode_q_reg <= PAR_EVEN;
    end else if (bus.clear || release_frame) begin
      cnt_reg    <= '0;
      row_reg    <= '0;
      col_reg    <= '0;
      mode_q_reg <= PAR_EVEN;
    end else if (accept) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
      row_reg <= row_next;
      col_reg <= col_reg ^ bus.in_data;
      if (state_reg == IDLE) begin
        mode_q_reg <= par_mode_t'(bus.mode);
      end
    end
  end

  assign bus.out_row_par = row_reg;
  assign bus.out_col_par = col_reg ^ {WIDTH{mode_q_bit}};
  assign bus.out_cnt     = cnt_reg;

endmodule
